// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and instruction register and runs a req/ack read
// against instruction memory. Misaligned PCs and memory timeouts raise a sticky fault.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic        fetch_done,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic             misaligned;
  logic             timeout_hit;

  assign misaligned  = |pc[1:0];
  assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // A PC load in IDLE takes priority over a fetch request in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!pc_load && fetch_start) begin
          state_next = misaligned ? FAULT : WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = FAULT;
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    fetch_done = 1'b0;
    busy       = 1'b0;
    fault      = 1'b0;
    case (state)
      WAIT: begin
        imem_req = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        fetch_done = 1'b1;
        busy       = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction register and the WAIT-state timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= PC_RESET;
      instr <= 32'h0000_0000;
      count <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end else if (fetch_start && !misaligned) begin
            count <= '0;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            pc    <= pc + 32'd4;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized fetch/load sequences checked against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst, clk_en, fetch_start, pc_load, imem_ack;
  logic [31:0] pc_load_val, imem_rdata;
  logic        imem_req, fetch_done, busy, fault;
  logic [31:0] imem_addr, pc, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  int checks = 0;
  int passes = 0;

  logic [31:0] model_pc;
  logic [31:0] model_instr;
  bit          model_fault;

  instr_fetch_unit #(.PC_RESET(32'h0), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .fetch_start(fetch_start),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .fetch_done(fetch_done),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit en, input bit start, input bit load,
                               input logic [31:0] load_val, input bit ack,
                               input logic [31:0] rdata);
    clk_en      = en;
    fetch_start = start;
    pc_load     = load;
    pc_load_val = load_val;
    imem_ack    = ack;
    imem_rdata  = rdata;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    model_pc    = 32'h0;
    model_instr = 32'h0;
    model_fault = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".pc"}, pc, model_pc);
    checkOutput({tag, ".instr"}, instr, model_instr);
    checkOutput({tag, ".req"}, {31'b0, imem_req}, 32'd0);
    checkOutput({tag, ".fault"}, {31'b0, fault}, {31'b0, model_fault});
  endtask

  task automatic loadPc(input logic [31:0] val, input bit with_start);
    applyStimulus(1'b1, with_start, 1'b1, val, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    if (!model_fault) model_pc = val;
    checkIdle("load");
    checkOutput("load.busy", {31'b0, busy}, {31'b0, model_fault ? 1'b0 : 1'b0});
  endtask

  // Fetch at the modelled PC; ack arrives after `delay` enabled no-ack edges.
  task automatic runFetch(input logic [31:0] data, input int delay, input bit gaps);
    int n = 0;
    int guard = 0;
    logic [31:0] exp_pc;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    fetch_start = 1'b0;
    if (model_pc[1:0] != 2'b00) begin
      model_fault = 1'b1;
      checkOutput("misalign.fault", {31'b0, fault}, 32'd1);
      checkIdle("misalign");
      return;
    end
    checkOutput("wait.req", {31'b0, imem_req}, 32'd1);
    checkOutput("wait.addr", imem_addr, model_pc);
    while (n < delay && n < TIMEOUT && guard < 400) begin
      guard++;
      clk_en     = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      imem_ack   = !clk_en && ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      tick();
      if (clk_en) n++;
      imem_ack = 1'b0;
      if (n < TIMEOUT) begin
        checkOutput("wait.hold_instr", instr, model_instr);
        checkOutput("wait.busy", {31'b0, busy}, 32'd1);
      end
    end
    checkOutput("wait.guard", guard, (guard < 400) ? guard : 0);
    clk_en = 1'b1;
    if (delay >= TIMEOUT) begin
      model_fault = 1'b1;
      checkOutput("timeout.fault", {31'b0, fault}, 32'd1);
      checkOutput("timeout.busy", {31'b0, busy}, 32'd0);
      checkIdle("timeout");
      return;
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack    = 1'b0;
    model_instr = data;
    exp_pc      = model_pc + 32'd4;
    model_pc    = exp_pc;
    checkOutput("done.pulse", {31'b0, fetch_done}, 32'd1);
    checkOutput("done.req", {31'b0, imem_req}, 32'd0);
    checkOutput("done.instr", instr, data);
    checkOutput("done.pc", pc, exp_pc);
    checkOutput("done.opcode", {26'b0, opcode}, (data >> 26) & 32'h3f);
    checkOutput("done.rs", {27'b0, rs}, (data >> 21) & 32'h1f);
    checkOutput("done.rt", {27'b0, rt}, (data >> 16) & 32'h1f);
    checkOutput("done.rd", {27'b0, rd}, (data >> 11) & 32'h1f);
    checkOutput("done.shamt", {27'b0, shamt}, (data >> 6) & 32'h1f);
    checkOutput("done.funct", {26'b0, funct}, data & 32'h3f);
    checkOutput("done.imm", {16'b0, imm}, data & 32'hffff);
    tick();
    checkOutput("after.pulse", {31'b0, fetch_done}, 32'd0);
    checkOutput("after.busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] frozen_pc;
    logic [31:0] frozen_instr;
    logic [31:0] val;

    doReset();
    checkIdle("reset");
    checkOutput("reset.done", {31'b0, fetch_done}, 32'd0);
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);

    runFetch(32'h2009_0005, 3, 1'b0);
    checkOutput("t1.opcode", {26'b0, opcode}, 32'h08);
    checkOutput("t1.rt", {27'b0, rt}, 32'd9);
    checkOutput("t1.imm", {16'b0, imm}, 32'h5);
    checkOutput("t1.pc", pc, 32'h4);

    loadPc(32'h0000_0100, 1'b1);
    checkOutput("t2.pc", pc, 32'h100);
    runFetch(32'hDEAD_BEEF, 0, 1'b0);
    checkOutput("t2.pc_after", pc, 32'h104);

    loadPc(32'h0000_0102, 1'b0);
    runFetch(32'h1234_5678, 0, 1'b0);
    checkOutput("t3.pc", pc, 32'h102);
    doReset();
    checkOutput("t3.fault_cleared", {31'b0, fault}, 32'd0);
    checkOutput("t3.pc_reset", pc, 32'h0);

    runFetch(32'h0, TIMEOUT, 1'b0);
    frozen_pc    = model_pc;
    frozen_instr = model_instr;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, (i % 2) == 1, 32'h0000_0040, 1'b1, 32'hFFFF_0000);
      tick();
      checkOutput("t4.fault", {31'b0, fault}, 32'd1);
      checkOutput("t4.req", {31'b0, imem_req}, 32'd0);
      checkOutput("t4.pc", pc, frozen_pc);
      checkOutput("t4.instr", instr, frozen_instr);
    end
    doReset();

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
      tick();
      checkOutput("t5.no_capture", instr, 32'h0);
      checkOutput("t5.req_held", {31'b0, imem_req}, 32'd1);
      checkOutput("t5.no_done", {31'b0, fetch_done}, 32'd0);
    end
    clk_en = 1'b1;
    tick();
    imem_ack = 1'b0;
    checkOutput("t5.capture", instr, 32'hCAFE_F00D);
    checkOutput("t5.done", {31'b0, fetch_done}, 32'd1);
    checkOutput("t5.pc", pc, 32'h4);
    tick();
    model_pc    = 32'h4;
    model_instr = 32'hCAFE_F00D;

    loadPc(32'hFFFF_FFFC, 1'b0);
    runFetch(32'h0000_0020, 1, 1'b0);
    checkOutput("t6.funct", {26'b0, funct}, 32'h20);
    checkOutput("t6.pc_wrap", pc, 32'h0);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    fetch_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t7.req_dropped", {31'b0, imem_req}, 32'd0);
    checkOutput("t7.busy", {31'b0, busy}, 32'd0);
    model_pc = 32'h0; model_instr = 32'h0; model_fault = 1'b0;

    for (int k = 0; k < 60; k++) begin
      if (model_fault) doReset();
      case ($urandom_range(0, 5))
        0: begin
          val = {$urandom_range(0, 255), 2'b00} << 2;
          if ($urandom_range(0, 4) == 0) val[1:0] = 2'($urandom_range(1, 3));
          loadPc(val, $urandom_range(0, 1) == 1);
        end
        1: runFetch($urandom, $urandom_range(TIMEOUT - 2, TIMEOUT + 1), 1'b0);
        default: runFetch($urandom, $urandom_range(0, 6), 1'b1);
      endcase
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage feeding the multicycle controller. It owns the PC and the instruction register, and runs a request/acknowledge read to instruction memory. It latches the returned word and presents the decoded fields (opcode, funct, rs, rt, rd, shamt, imm) to the controller and datapath. Fetches are started by the controller's fetch pulse. Misaligned PCs and memory timeouts are reported as a sticky fault.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max clk_en cycles in WAIT without ack before FAULT (>=1)
CNT_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global step enable; all state updates gated by it
fetch_start  in  1  controller request to fetch the instruction at pc
pc_load  in  1  load pc from pc_load_val (branch/jump)
pc_load_val  in  32  new PC value
imem_req  out  1  memory read request (level)
imem_addr  out  32  read address, equals pc while imem_req=1
imem_rdata  in  32  read data, valid when imem_ack=1
imem_ack  in  1  read acknowledge (level, held until sampled)
pc  out  32  current PC
instr  out  32  instruction register
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm  out  16  instr[15:0]
fetch_done  out  1  one-cycle pulse: instr updated
busy  out  1  state is WAIT or DONE
fault  out  1  sticky error flag

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. rst takes effect on a clk edge regardless of clk_en.
- Reset values: pc=PC_RESET, instr=0, state=IDLE, counter=0. imem_req=0, fetch_done=0, busy=0, fault=0.
- Decoded fields are combinational slices of instr. imem_addr=pc at all times.
- All registered updates occur only on edges with clk_en=1. When clk_en=0, state holds and outputs hold.
- FSM states: IDLE, WAIT, DONE, FAULT.
- IDLE:
  - pc_load=1: pc<=pc_load_val, stay IDLE. If fetch_start is also 1, it is ignored that cycle (load wins).
  - Else fetch_start=1 and pc[1:0]==0: counter<=0, go WAIT.
  - Else fetch_start=1 and pc[1:0]!=0: go FAULT; no request is issued.
- WAIT:
  - imem_req=1.
  - imem_ack=1: instr<=imem_rdata, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), go DONE.
  - Else counter<=counter+1. When counter==TIMEOUT-1 without ack, go FAULT.
  - pc_load and fetch_start are ignored.
- DONE:
  - fetch_done=1 and imem_req=0 for exactly one clk_en cycle, then IDLE.
  - pc_load and fetch_start are ignored.
- FAULT: fault=1, imem_req=0, instr and pc frozen, all inputs ignored. Exit only via rst.
- Latency: with ack held high, fetch_start edge -> WAIT; next edge captures instr -> DONE. fetch_done is high for the cycle after capture. Minimum is 2 clk_en edges from fetch_start to fetch_done.
- Handshake: imem_req is state-decoded, so it is high for the entire WAIT. The memory holds ack/rdata until it sees req drop. An ack with req=0 is ignored.
- rst during WAIT aborts the request; imem_req drops the cycle after the reset edge.

Test Plan:
- Reset, mem returns 32'h2009_0005 with ack 3 cycles after req, fetch_start pulse -> imem_addr=0 during WAIT; instr=2009_0005, opcode=6'h08, rt=9, imm=16'h0005, pc=4; fetch_done high one cycle.
- pc_load=1 with pc_load_val=32'h0000_0100 and fetch_start=1 in the same IDLE cycle -> pc=0x100, no imem_req. A following fetch_start reads addr 0x100, and pc becomes 0x104 afterwards.
- pc_load_val=32'h0000_0102, then fetch_start -> fault=1 next cycle, imem_req never asserted, pc stays 0x102. rst clears fault and pc=0.
- No ack for TIMEOUT=16 clk_en cycles after entering WAIT -> fault=1, imem_req=0. A later ack and fetch_start cause no change.
- clk_en low for 5 cycles mid-WAIT with ack asserted -> no capture while clk_en=0. Capture happens on the first clk_en=1 edge.
- pc_load_val=32'hFFFF_FFFC, fetch with rdata 32'h0000_0020 -> funct=6'h20, pc wraps to 0.
